pcileech_bar_cpl_builder_bcm: RTL and testbench

// - Downstream stage of the BCM BAR register model. It buffers the read responses that the

---
 rtl/pcileech_bar_cpl_builder_bcm.sv | 124 ++++++++++++
 tb/tb_pcileech_bar_cpl_builder_bcm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_bar_cpl_builder_bcm.sv
// Buffers BAR-model read responses and emits them as one-beat 128-bit CplD / Cpl-UR TLPs.
// Optional BCM_CPL_STATS_EN adds saturating completion and drop counters.
module pcileech_bar_cpl_builder_bcm #(
    parameter int DEPTH      = 16,
    parameter int STALL_MARG = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [87:0]  rd_rsp_ctx,
    input  logic [31:0]  rd_rsp_data,
    input  logic         rd_rsp_valid,
    input  logic [15:0]  completer_id,
    output logic         rd_stall,
    output logic [127:0] tlp_tdata,
    output logic [3:0]   tlp_tkeep,
    output logic         tlp_tlast,
    output logic         tlp_tvalid,
    input  logic         tlp_tready,
    output logic         ovf_sticky
`ifdef BCM_CPL_STATS_EN
    ,
    output logic [31:0]  stat_cpl_cnt,
    output logic [15:0]  stat_drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_C  = DEPTH[AW:0];
    localparam logic [AW:0]   STALL_C = FULL_C - STALL_MARG[AW:0];
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;
    state_t state, state_nxt;

    logic [78:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count, count_nxt;
    logic          push, drop, pop, not_empty;
    logic          unused_ctx;

    assign unused_ctx = ^rd_rsp_ctx[87:47];
    // Full is judged on the current count, so a push is dropped even if a pop lands this cycle.
    assign not_empty = (count != '0);
    assign push      = rd_rsp_valid && (count < FULL_C);
    assign drop      = rd_rsp_valid && (count >= FULL_C);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            EMPTY: if (not_empty) begin
                pop       = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: if (tlp_tready) begin
                if (not_empty) pop = 1'b1;
                else           state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + CNT_ONE;
        else if (!push && pop) count_nxt = count - CNT_ONE;
    end

    // Completion fields decoded from the FIFO head.
    logic [78:0]  head;
    logic         h_ur;
    logic [127:0] cpl;
    assign head = mem[rptr];
    assign h_ur = head[46];
    assign cpl[31:0]   = {h_ur ? 3'b000 : 3'b010, 5'b01010, 1'b0, head[33:31], 10'd0,
                          h_ur ? 10'd0 : 10'd1};
    assign cpl[63:32]  = {completer_id, h_ur ? 3'b001 : 3'b000, 1'b0,
                          h_ur ? 12'd4 : head[45:34]};
    assign cpl[95:64]  = {head[15:0], head[23:16], 1'b0, head[30:24]};
    assign cpl[127:96] = h_ur ? 32'd0 : head[78:47];

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {rd_rsp_data, rd_rsp_ctx[46:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            rd_stall   <= 1'b0;
            ovf_sticky <= 1'b0;
            tlp_tdata  <= '0;
            tlp_tkeep  <= '0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            rd_stall <= (count_nxt >= STALL_C);
            if (push) wptr <= wptr + PTR_ONE;
            if (pop) begin
                rptr      <= rptr + PTR_ONE;
                tlp_tdata <= cpl;
                tlp_tkeep <= h_ur ? 4'b0111 : 4'b1111;
            end
            if (drop) ovf_sticky <= 1'b1;
        end
    end

    assign tlp_tvalid = (state == HOLD);
    assign tlp_tlast  = tlp_tvalid;

`ifdef BCM_CPL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cpl_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (tlp_tvalid && tlp_tready && (stat_cpl_cnt != '1)) stat_cpl_cnt <= stat_cpl_cnt + 32'd1;
            if (drop && (stat_drop_cnt != '1)) stat_drop_cnt <= stat_drop_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pcileech_bar_cpl_builder_bcm.sv
// Randomised bench for the completion builder: queue-level reference model plus literal spot checks.
module tb_pcileech_bar_cpl_builder_bcm;
    localparam int DEPTH = 16;
    localparam int STALL_MARG = 2;

    logic         clk = 0;
    logic         rst_n = 0;
    logic [87:0]  rd_rsp_ctx = '0;
    logic [31:0]  rd_rsp_data = '0;
    logic         rd_rsp_valid = 0;
    logic [15:0]  completer_id = 16'hABCD;
    logic         rd_stall;
    logic [127:0] tlp_tdata;
    logic [3:0]   tlp_tkeep;
    logic         tlp_tlast, tlp_tvalid;
    logic         tlp_tready = 0;
    logic         ovf_sticky;
`ifdef BCM_CPL_STATS_EN
    logic [31:0]  stat_cpl_cnt;
    logic [15:0]  stat_drop_cnt;
`endif

    pcileech_bar_cpl_builder_bcm #(.DEPTH(DEPTH), .STALL_MARG(STALL_MARG)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_rsp_ctx(rd_rsp_ctx), .rd_rsp_data(rd_rsp_data), .rd_rsp_valid(rd_rsp_valid),
        .completer_id(completer_id), .rd_stall(rd_stall),
        .tlp_tdata(tlp_tdata), .tlp_tkeep(tlp_tkeep), .tlp_tlast(tlp_tlast),
        .tlp_tvalid(tlp_tvalid), .tlp_tready(tlp_tready), .ovf_sticky(ovf_sticky)
`ifdef BCM_CPL_STATS_EN
        , .stat_cpl_cnt(stat_cpl_cnt), .stat_drop_cnt(stat_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Completion as the header rules describe it.
    function automatic logic [127:0] mk(input logic [46:0] c, input logic [31:0] d, input logic [15:0] cid);
        logic [31:0] dw0, dw1, dw2, dw3;
        logic ur;
        ur  = c[46];
        dw0 = (ur ? 32'h0A00_0000 : 32'h4A00_0001) | (32'(c[33:31]) << 20);
        dw1 = (32'(cid) << 16) | (ur ? (32'd1 << 13) | 32'd4 : 32'(c[45:34]));
        dw2 = (32'(c[15:0]) << 16) | (32'(c[23:16]) << 8) | 32'(c[30:24]);
        dw3 = ur ? 32'd0 : d;
        return {dw3, dw2, dw1, dw0};
    endfunction

    typedef struct {logic [46:0] c; logic [31:0] d;} ent_t;
    ent_t        q[$];
    ent_t        e;
    logic        m_valid, m_stall, m_ovf, full, hs;
    logic [127:0] m_data;
    logic [3:0]  m_keep;
    longint      m_cpl, m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_valid = 0; m_data = '0; m_keep = '0; m_stall = 0; m_ovf = 0;
            m_cpl = 0; m_drop = 0;
        end else begin
            full = (q.size() == DEPTH);
            hs   = m_valid && tlp_tready;
            if (hs && m_cpl < 64'hFFFF_FFFF) m_cpl++;
            if (q.size() > 0 && (!m_valid || tlp_tready)) begin
                e = q.pop_front();
                m_data = mk(e.c, e.d, completer_id);
                m_keep = e.c[46] ? 4'h7 : 4'hF;
                m_valid = 1;
            end else if (hs) m_valid = 0;
            if (rd_rsp_valid) begin
                if (!full) q.push_back('{rd_rsp_ctx[46:0], rd_rsp_data});
                else begin
                    m_ovf = 1;
                    if (m_drop < 64'hFFFF) m_drop++;
                end
            end
            m_stall = (q.size() >= DEPTH - STALL_MARG);
        end
    end

    int hs_cnt = 0, stall_seen = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("tvalid", 128'(tlp_tvalid), 128'(m_valid));
            chk("tlast", 128'(tlp_tlast), 128'(m_valid));
            if (m_valid) begin
                chk("tdata", tlp_tdata, m_data);
                chk("tkeep", 128'(tlp_tkeep), 128'(m_keep));
            end
            chk("rd_stall", 128'(rd_stall), 128'(m_stall));
            chk("ovf_sticky", 128'(ovf_sticky), 128'(m_ovf));
`ifdef BCM_CPL_STATS_EN
            chk("stat_cpl", 128'(stat_cpl_cnt), 128'(m_cpl));
            chk("stat_drop", 128'(stat_drop_cnt), 128'(m_drop));
`endif
            if (tlp_tvalid && tlp_tready) hs_cnt++;
            if (rd_stall) stall_seen++;
        end
    end

    task automatic cyc(); @(posedge clk); #1; endtask

    function automatic logic [87:0] ctx(input logic [15:0] rid, input logic [7:0] tag,
                                        input logic [6:0] la, input logic [2:0] tc,
                                        input logic [11:0] bc, input logic ur);
        return {41'd0, ur, bc, tc, la, tag, rid};
    endfunction

    task automatic strobe(input logic [87:0] c, input logic [31:0] d);
        rd_rsp_ctx = c; rd_rsp_data = d; rd_rsp_valid = 1; cyc(); rd_rsp_valid = 0;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_tvalid", 128'(tlp_tvalid), 128'd0);
        chk("rst_tdata", tlp_tdata, 128'd0);
        chk("rst_stall", 128'(rd_stall), 128'd0);
        chk("rst_ovf", 128'(ovf_sticky), 128'd0);
        cyc(); rst_n = 1; tlp_tready = 1; cyc();

        // single read: beat appears two edges after the strobe
        rd_rsp_ctx = ctx(16'h0100, 8'h05, 7'h04, 3'd0, 12'd4, 1'b0);
        rd_rsp_data = 32'h0000_0400; rd_rsp_valid = 1;
        cyc(); rd_rsp_valid = 0;
        @(negedge clk); chk("single_not_early", 128'(tlp_tvalid), 128'd0);
        @(negedge clk);
        chk("single_valid", 128'(tlp_tvalid), 128'd1);
        chk("single_dw0", 128'(tlp_tdata[31:0]), 128'h4A00_0001);
        chk("single_dw1", 128'(tlp_tdata[63:32]), 128'hABCD_0004);
        chk("single_dw2", 128'(tlp_tdata[95:64]), 128'h0100_0504);
        chk("single_dw3", 128'(tlp_tdata[127:96]), 128'h0000_0400);
        chk("single_keep", 128'(tlp_tkeep), 128'hF);
        repeat (3) cyc();

        // back-to-back burst of 8
        hs_cnt = 0; stall_seen = 0;
        for (int i = 0; i < 8; i++) begin
            rd_rsp_ctx = ctx(16'h0200, 8'(i), 7'(i * 4), 3'd1, 12'd4, 1'b0);
            rd_rsp_data = $urandom; rd_rsp_valid = 1; cyc();
        end
        rd_rsp_valid = 0;
        repeat (4) cyc();
        chk("burst_beats", 128'(hs_cnt), 128'd8);
        chk("burst_no_stall", 128'(stall_seen), 128'd0);

        // unsupported request
        strobe(ctx(16'h0300, 8'h22, 7'h10, 3'd0, 12'd8, 1'b1), 32'hDEAD_BEEF);
        @(negedge clk); @(negedge clk);
        chk("ur_dw0", 128'(tlp_tdata[31:0]), 128'h0A00_0000);
        chk("ur_status", 128'(tlp_tdata[47:45]), 128'd1);
        chk("ur_keep", 128'(tlp_tkeep), 128'h7);
        chk("ur_dw3", 128'(tlp_tdata[127:96]), 128'd0);
        repeat (3) cyc();

        // backpressure and overflow: 1 in output register, 16 buffered, 18th dropped
        tlp_tready = 0;
        for (int i = 0; i < 18; i++) begin
            rd_rsp_ctx = ctx(16'h0400, 8'(i), 7'd0, 3'd2, 12'd4, 1'b0);
            rd_rsp_data = $urandom; rd_rsp_valid = 1; cyc();
        end
        rd_rsp_valid = 0;
        @(negedge clk);
        chk("ovf_set", 128'(ovf_sticky), 128'd1);
        chk("ovf_stall", 128'(rd_stall), 128'd1);
`ifdef BCM_CPL_STATS_EN
        chk("ovf_drop_cnt", 128'(stat_drop_cnt), 128'd1);
`endif
        // full with tready=1 and a concurrent push: push must be dropped
        cyc();
        tlp_tready = 1; rd_rsp_ctx = ctx(16'h0500, 8'hEE, 7'd0, 3'd0, 12'd4, 1'b0);
        rd_rsp_valid = 1; cyc(); rd_rsp_valid = 0;
        repeat (20) cyc();

        // randomised traffic with bursts of backpressure
        for (int i = 0; i < 3000; i++) begin
            rd_rsp_ctx = {$urandom, $urandom, $urandom};
            rd_rsp_ctx[46] = ($urandom_range(0, 3) == 0);
            rd_rsp_data = $urandom;
            rd_rsp_valid = ($urandom_range(0, 99) < ((i % 400) < 100 ? 80 : 45));
            tlp_tready = ($urandom_range(0, 99) < ((i % 400) < 100 ? 20 : 75));
            cyc();
        end
        rd_rsp_valid = 0; tlp_tready = 1;
        repeat (25) cyc();

        // reset mid-stream with one beat held and three buffered
        tlp_tready = 0;
        for (int i = 0; i < 4; i++) strobe(ctx(16'h0600, 8'(i), 7'd0, 3'd0, 12'd4, 1'b0), $urandom);
        cyc();
        chk("pre_rst_valid", 128'(tlp_tvalid), 128'd1);
        #2 rst_n = 0; #1;
        chk("rst_async_tvalid", 128'(tlp_tvalid), 128'd0);
        cyc(); cyc(); rst_n = 1; tlp_tready = 1;
        hs_cnt = 0;
        repeat (6) cyc();
        chk("post_rst_quiet", 128'(hs_cnt), 128'd0);
        chk("post_rst_ovf", 128'(ovf_sticky), 128'd0);
        strobe(ctx(16'h0700, 8'h33, 7'h08, 3'd0, 12'd4, 1'b0), 32'h1234_5678);
        repeat (3) cyc();
        chk("post_rst_beat", 128'(hs_cnt), 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
